// File: rtl/interp_rr_arbiter.sv
//============================================================================
// Module      : interp_rr_arbiter
// Description : Round-robin arbiter that lets N_CH source channels share one
//               interpolator source port. A granted channel keeps the port
//               for up to BURST_LEN transfers, or until it has shown no valid
//               for IDLE_TIMEOUT consecutive cycles. Every release costs one
//               IDLE cycle, during which the next requester is chosen
//               starting after the last granted channel.
// Ports       : clk, arst                 - clock, async active-high reset
//               ch_data_in/valid/bypass   - per-channel source side
//               ch_ready_out              - per-channel ready (granted only)
//               interp_data/valid/bypass  - muxed stream to interpolator
//               interp_ready_in           - backpressure from interpolator
//               grant_out, grant_idx_out  - one-hot grant / grant index
//               burst_done_out            - pulse after a full-length burst
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module interp_rr_arbiter #(
    parameter int N_CH         = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int BURST_LEN    = 8,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic [N_CH*DATA_WIDTH-1:0]   ch_data_in,
    input  logic [N_CH-1:0]              ch_valid_in,
    output logic [N_CH-1:0]              ch_ready_out,
    input  logic [N_CH-1:0]              ch_bypass_in,
    output logic [DATA_WIDTH-1:0]        interp_data_out,
    output logic                         interp_valid_out,
    input  logic                         interp_ready_in,
    output logic                         interp_bypass_out,
    output logic [N_CH-1:0]              grant_out,
    output logic [$clog2(N_CH)-1:0]      grant_idx_out,
    output logic                         burst_done_out
);

    localparam int c_IDX_W  = $clog2(N_CH);
    localparam int c_BEAT_W = $clog2(BURST_LEN + 1);
    localparam int c_IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);
    // Reset points last_grant at the top channel so channel 0 wins first.
    localparam logic [c_IDX_W-1:0]  c_LAST_RST  = c_IDX_W'(N_CH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                r_state,      w_nxt_state;
    logic [c_IDX_W-1:0]    r_grant,      w_nxt_grant;
    logic [c_IDX_W-1:0]    r_last_grant, w_nxt_last_grant;
    logic [c_BEAT_W-1:0]   r_beat_cnt,   w_nxt_beat_cnt;
    logic [c_IDLE_W-1:0]   r_idle_cnt,   w_nxt_idle_cnt;
    logic                  r_burst_done, w_nxt_burst_done;

    logic                  w_req_found;
    logic [c_IDX_W-1:0]    w_req_idx;
    logic                  w_g_valid;
    logic                  w_xfer;

    //------------------------------------------------------------------------
    // Rotating-priority search: first valid channel after last_grant.
    // The candidate list wraps, so last_grant itself is checked last; that
    // lets a sole requester be re-granted after its own release.
    //------------------------------------------------------------------------
    always_comb begin : p_arb
        int                 v_cand;
        logic [c_IDX_W-1:0] v_idx;
        v_cand      = 0;
        v_idx       = '0;
        w_req_found = 1'b0;
        w_req_idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            v_cand = (int'(r_last_grant) + k) % N_CH;
            v_idx  = c_IDX_W'(v_cand);
            if (!w_req_found && ch_valid_in[v_idx]) begin
                w_req_found = 1'b1;
                w_req_idx   = v_idx;
            end
        end
    end

    assign w_g_valid = ch_valid_in[r_grant];
    assign w_xfer    = (r_state == S_GRANT) && w_g_valid && interp_ready_in;

    //------------------------------------------------------------------------
    // Zero-latency datapath: the granted channel is wired straight through.
    //------------------------------------------------------------------------
    always_comb begin : p_out
        ch_ready_out      = '0;
        grant_out         = '0;
        interp_data_out   = '0;
        interp_valid_out  = 1'b0;
        interp_bypass_out = 1'b0;
        grant_idx_out     = r_last_grant;
        if (r_state == S_GRANT) begin
            interp_data_out       = ch_data_in[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
            interp_valid_out      = w_g_valid;
            interp_bypass_out     = ch_bypass_in[r_grant];
            ch_ready_out[r_grant] = interp_ready_in;
            grant_out[r_grant]    = 1'b1;
            grant_idx_out         = r_grant;
        end
    end

    assign burst_done_out = r_burst_done;

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin : p_next
        w_nxt_state      = r_state;
        w_nxt_grant      = r_grant;
        w_nxt_last_grant = r_last_grant;
        w_nxt_beat_cnt   = r_beat_cnt;
        w_nxt_idle_cnt   = r_idle_cnt;
        w_nxt_burst_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req_found) begin
                    w_nxt_state    = S_GRANT;
                    w_nxt_grant    = w_req_idx;
                    w_nxt_beat_cnt = '0;
                    w_nxt_idle_cnt = '0;
                end
            end

            S_GRANT: begin
                if (w_xfer) begin
                    // A transfer clears idle_cnt, so burst completion and
                    // timeout can never fire together; completion is tested
                    // first regardless.
                    w_nxt_idle_cnt = '0;
                    if (r_beat_cnt == c_BEAT_LAST) begin
                        w_nxt_state      = S_IDLE;
                        w_nxt_last_grant = r_grant;
                        w_nxt_beat_cnt   = '0;
                        w_nxt_burst_done = 1'b1;
                    end else begin
                        w_nxt_beat_cnt = r_beat_cnt + 1'b1;
                    end
                end else if (!w_g_valid) begin
                    // Dropped valid is tolerated; only a long gap releases.
                    if (r_idle_cnt == c_IDLE_LAST) begin
                        w_nxt_state      = S_IDLE;
                        w_nxt_last_grant = r_grant;
                        w_nxt_beat_cnt   = '0;
                        w_nxt_idle_cnt   = '0;
                    end else begin
                        w_nxt_idle_cnt = r_idle_cnt + 1'b1;
                    end
                end else begin
                    // Valid held under backpressure: channel is still active.
                    w_nxt_idle_cnt = '0;
                end
            end

            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // State registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_RST;
            r_beat_cnt   <= '0;
            r_idle_cnt   <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_grant      <= w_nxt_grant;
            r_last_grant <= w_nxt_last_grant;
            r_beat_cnt   <= w_nxt_beat_cnt;
            r_idle_cnt   <= w_nxt_idle_cnt;
            r_burst_done <= w_nxt_burst_done;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_interp_rr_arbiter.sv
//============================================================================
// Module      : tb_interp_rr_arbiter
// Description : Directed self-checking bench for interp_rr_arbiter with the
//               default parameters (4 channels, 16-bit data, burst 8,
//               timeout 4). Inputs change 1 ns after a rising edge and
//               outputs are compared 1 ns later, mid-cycle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_interp_rr_arbiter;

    logic        clk;
    logic        arst;
    logic [63:0] ch_data_in;
    logic [3:0]  ch_valid_in;
    logic [3:0]  ch_ready_out;
    logic [3:0]  ch_bypass_in;
    logic [15:0] interp_data_out;
    logic        interp_valid_out;
    logic        interp_ready_in;
    logic        interp_bypass_out;
    logic [3:0]  grant_out;
    logic [1:0]  grant_idx_out;
    logic        burst_done_out;

    int n_checks;
    int n_fail;

    interp_rr_arbiter #(
        .N_CH         (4),
        .DATA_WIDTH   (16),
        .BURST_LEN    (8),
        .IDLE_TIMEOUT (4)
    ) dut (
        .clk               (clk),
        .arst              (arst),
        .ch_data_in        (ch_data_in),
        .ch_valid_in       (ch_valid_in),
        .ch_ready_out      (ch_ready_out),
        .ch_bypass_in      (ch_bypass_in),
        .interp_data_out   (interp_data_out),
        .interp_valid_out  (interp_valid_out),
        .interp_ready_in   (interp_ready_in),
        .interp_bypass_out (interp_bypass_out),
        .grant_out         (grant_out),
        .grant_idx_out     (grant_idx_out),
        .burst_done_out    (burst_done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output for the current cycle, then move to 1 ns past
    // the next rising edge, where the caller may update inputs.
    task automatic cyc(input string tag, input int e_grant, input int e_valid,
                       input int e_ready, input int e_data, input int e_done,
                       input int e_idx, input int e_byp);
        #1;
        chk({tag, ".grant"},  32'(grant_out),         32'(e_grant));
        chk({tag, ".valid"},  32'(interp_valid_out),  32'(e_valid));
        chk({tag, ".ready"},  32'(ch_ready_out),      32'(e_ready));
        chk({tag, ".data"},   32'(interp_data_out),   32'(e_data));
        chk({tag, ".done"},   32'(burst_done_out),    32'(e_done));
        chk({tag, ".idx"},    32'(grant_idx_out),     32'(e_idx));
        chk({tag, ".bypass"}, 32'(interp_bypass_out), 32'(e_byp));
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] c_DATA = 64'hC003_C002_C001_C000;

    initial begin
        int order [5];
        int k;
        order = '{0, 1, 2, 3, 0};
        n_checks = 0;
        n_fail   = 0;

        // Reset held with all channels requesting: nothing may be granted.
        arst            = 1'b1;
        ch_valid_in     = 4'b1111;
        interp_ready_in = 1'b1;
        ch_bypass_in    = 4'b0100;
        ch_data_in      = c_DATA;
        @(posedge clk);
        #1;
        cyc("rst", 0, 0, 0, 0, 0, 3, 0);
        arst = 1'b0;

        // Full round robin, 8 beats each, bypass only on channel 2.
        for (int s = 0; s < 5; s++) begin
            int ch;
            int prev;
            ch   = order[s];
            prev = (s == 0) ? 3 : order[s-1];
            cyc("rr_bubble", 0, 0, 0, 0, (s != 0) ? 1 : 0, prev, 0);
            for (int b = 0; b < 8; b++)
                cyc("rr_beat", 1 << ch, 1, 1 << ch, 32'hC000 + ch, 0, ch, (ch == 2) ? 1 : 0);
        end

        // No requesters: stay idle; done pulse lasts one cycle only.
        ch_valid_in = 4'b0000;
        cyc("idle_done", 0, 0, 0, 0, 1, 0, 0);
        cyc("idle_hold", 0, 0, 0, 0, 0, 0, 0);

        // Only channel 2 requests: granted one cycle after valid seen.
        ch_valid_in = 4'b0100;
        cyc("ch2_see", 0, 0, 0, 0, 0, 0, 0);
        for (int b = 0; b < 8; b++)
            cyc("ch2_beat", 4'b0100, 1, 4'b0100, 32'hC002, 0, 2, 1);
        cyc("ch2_bubble", 0, 0, 0, 0, 1, 2, 0);
        cyc("ch2_regrant", 4'b0100, 1, 4'b0100, 32'hC002, 0, 2, 1);

        // Channel 2 goes quiet: four empty grant cycles, then release.
        ch_valid_in = 4'b0000;
        for (int i = 0; i < 4; i++)
            cyc("ch2_quiet", 4'b0100, 0, 4'b0100, 32'hC002, 0, 2, 1);
        ch_valid_in = 4'b0010;
        cyc("ch2_timeout", 0, 0, 0, 0, 0, 2, 0);

        // Channel 1: three beats, then drops valid while channel 3 asks.
        for (int b = 0; b < 3; b++)
            cyc("ch1_beat", 4'b0010, 1, 4'b0010, 32'hC001, 0, 1, 0);
        ch_valid_in = 4'b1000;
        for (int i = 0; i < 4; i++)
            cyc("ch1_quiet", 4'b0010, 0, 4'b0010, 32'hC001, 0, 1, 0);
        cyc("ch1_timeout", 0, 0, 0, 0, 0, 1, 0);
        for (int b = 0; b < 4; b++)
            cyc("ch3_beat", 4'b1000, 1, 4'b1000, 32'hC003, 0, 3, 0);

        // Reset during beat 5 of channel 3: outputs drop in the same cycle.
        arst        = 1'b1;
        ch_valid_in = 4'b1111;
        cyc("mid_rst", 0, 0, 0, 0, 0, 3, 0);
        cyc("mid_rst_hold", 0, 0, 0, 0, 0, 3, 0);
        arst = 1'b0;
        cyc("post_rst_bubble", 0, 0, 0, 0, 0, 3, 0);

        // Channel 0 with toggling backpressure: 8 transfers over 15 cycles.
        k = 0;
        for (int c = 0; c < 15; c++) begin
            interp_ready_in  = (c % 2 == 0);
            ch_data_in[15:0] = 16'(16'h0100 + k);
            cyc("bp_beat", 4'b0001, 1, {3'b000, interp_ready_in}, 32'h0100 + k, 0, 0, 0);
            if (c % 2 == 0)
                k++;
        end
        interp_ready_in  = 1'b1;
        ch_data_in[15:0] = 16'hC000;
        cyc("bp_bubble", 0, 0, 0, 0, 1, 0, 0);
        cyc("bp_next", 4'b0010, 1, 4'b0010, 32'hC001, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/interp_rr_arbiter.md
INTERP_RR_ARBITER -- requirements
Module: interp_rr_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of source channels sharing one interpolator (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, signed sample width per channel.
REQ-003 SHALL have parameter BURST_LEN, default 8, maximum transfers per grant (>=1).
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 4, consecutive cycles without valid on the granted channel before release (>=1).
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port arst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port ch_data_in, input, N_CH*DATA_WIDTH, channel i sample at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port ch_valid_in, input, N_CH, per-channel valid.
REQ-009 SHALL have port ch_ready_out, output, N_CH, per-channel ready.
REQ-010 SHALL have port ch_bypass_in, input, N_CH, per-channel interpolator bypass configuration.
REQ-011 SHALL have port interp_data_out, output, DATA_WIDTH, sample to interpolator source port.
REQ-012 SHALL have port interp_valid_out, output, 1, valid to interpolator source port.
REQ-013 SHALL have port interp_ready_in, input, 1, ready from interpolator source port.
REQ-014 SHALL have port interp_bypass_out, output, 1, bypass select to interpolator.
REQ-015 SHALL have port grant_out, output, N_CH, one-hot current grant (all zero when idle).
REQ-016 SHALL have port grant_idx_out, output, $clog2(N_CH), index of current/last grant.
REQ-017 SHALL have port burst_done_out, output, 1, one-cycle pulse when a grant ends by reaching BURST_LEN.

Function
REQ-018 SHALL implement FSM states IDLE and GRANT; registered state, grant, last_grant, beat_cnt, idle_cnt.
REQ-019 IDLE: if any ch_valid_in bit set, SHALL select first set channel searching last_grant+1, +2, ... modulo N_CH, register it as grant, enter GRANT next edge; otherwise stay IDLE.
REQ-020 IDLE: interp_valid_out, ch_ready_out, grant_out, interp_bypass_out SHALL be 0.
REQ-021 GRANT (channel g): interp_data_out = ch_data_in[g], interp_valid_out = ch_valid_in[g], ch_ready_out[g] = interp_ready_in, all other ch_ready_out bits 0; combinational, zero-latency path.
REQ-022 GRANT: interp_bypass_out SHALL equal ch_bypass_in[g].
REQ-023 Transfer SHALL be ch_valid_in[g] & interp_ready_in; each transfer increments beat_cnt.
REQ-024 Transfer with beat_cnt = BURST_LEN-1 SHALL release: next state IDLE, beat_cnt=0, idle_cnt=0, last_grant=g, burst_done_out=1 for the cycle following that edge.
REQ-025 idle_cnt SHALL increment each GRANT cycle with ch_valid_in[g]=0, clear when ch_valid_in[g]=1; reaching IDLE_TIMEOUT SHALL release (last_grant=g) without burst_done_out.
REQ-026 Release SHALL occur only at a clock edge; grant SHALL never change while ch_valid_in[g]=1 and the current beat is unaccepted, except by burst completion.
REQ-027 Burst completion and timeout in same cycle: impossible by construction (transfer clears idle_cnt); burst completion wins if ever both evaluated.
REQ-028 Release to next grant SHALL take exactly one IDLE cycle (one bubble).
REQ-029 grant_idx_out SHALL show g in GRANT, last_grant in IDLE.
REQ-030 Upstream valid dropped without transfer SHALL be tolerated (counts toward timeout); no data buffered inside block.
REQ-031 Only one channel SHALL ever see ch_ready_out=1 in any cycle.

Reset
REQ-032 arst=1 SHALL immediately force IDLE, beat_cnt=0, idle_cnt=0, last_grant=N_CH-1 (channel 0 first priority), burst_done_out=0, all outputs 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no further ready to that channel; first grant after release goes to lowest-index valid channel.

Verification
REQ-034 After reset, ch_valid_in=4'b1111, interp_ready_in=1, BURST_LEN=8 -> grants ch0 (8 beats), bubble, ch1, ch2, ch3, ch0; burst_done_out pulses after each 8th beat.
REQ-035 Only ch2 valid, interp_ready_in=1 -> grant ch2 one cycle after valid seen, 8 beats, bubble, ch2 re-granted (sole requester).
REQ-036 ch1 granted, ch1 valid drops after 3 beats, ch3 valid -> after 4 idle cycles release (no burst_done_out), ch3 granted after one bubble.
REQ-037 interp_ready_in toggled 1/0 every cycle during ch0 burst -> exactly 8 transfers in ~16 cycles, data order preserved, no grant change before 8th transfer.
REQ-038 ch_bypass_in=4'b0100, round robin over all channels -> interp_bypass_out=1 only while grant_out=4'b0100.
REQ-039 arst pulsed at beat 5 of ch3 burst -> outputs zero same cycle; after release ch0 granted first.
